vga_scanout: RTL and testbench



---
 rtl/video_timing_pkg.sv | 49 ++++
 rtl/vga_scanout_if.sv | 18 +
 rtl/video_delay_line.sv | 33 +++
 rtl/vga_scanout.sv | 137 +++++++++++++
 tb/tb_vga_scanout.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// ============================================================================
// video_timing_pkg : 640x480@60 timing constants, RGB565 field slices and the
//                    control word carried alongside the framebuffer pipeline.
// Revision 1.0
// ============================================================================
`default_nettype none

package video_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int R5_MSB = 15;
  localparam int R5_LSB = 11;
  localparam int G6_MSB = 10;
  localparam int G6_LSB = 5;
  localparam int B5_MSB = 4;
  localparam int B5_LSB = 0;

  typedef struct packed {
    logic frame_start;
    logic vsync;
    logic hsync;
    logic blank;
  } vid_ctrl_t;

  // Replicate the top bits into the low bits so full-scale maps to 8'hFF.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] px);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = px[R5_MSB:R5_LSB];
    g6 = px[G6_MSB:G6_LSB];
    b5 = px[B5_MSB:B5_LSB];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_scanout_if.sv
// ============================================================================
// vga_scanout_if : framebuffer read bus between scanout (master) and memory.
// Revision 1.0
// ============================================================================
`default_nettype none

interface vga_scanout_if #(
  parameter int FB_ADDR_W = 19
) ();
  logic                 fb_rd;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [15:0]          fb_data;

  modport master (output fb_rd, output fb_addr, input fb_data);
  modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

`default_nettype wire

// File: rtl/video_delay_line.sv
// ============================================================================
// video_delay_line : DEPTH x WIDTH shift register, async reset to RESET_VAL.
// Revision 1.0
// ============================================================================
`default_nettype none

module video_delay_line #(
  parameter int               DEPTH     = 4,
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_scanout.sv
// ============================================================================
// vga_scanout : video timing generator + linear framebuffer scanout, RGB565
//               expanded to RGB888 with blank/sync aligned to the pixel data.
// Revision 1.0
// ============================================================================
`default_nettype none

module vga_scanout
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int FB_ADDR_W  = 19,
  parameter int FB_LATENCY = 2
) (
  input  wire logic         pclk,
  input  wire logic         rst,
  vga_scanout_if.master     fb,
  output logic [7:0]        out_vga_red,
  output logic [7:0]        out_vga_green,
  output logic [7:0]        out_vga_blue,
  output logic              out_vga_blank,
  output logic              out_vga_hsync,
  output logic              out_vga_vsync,
  output logic              out_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D       = FB_LATENCY + 2;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam vid_ctrl_t CTRL_IDLE = '{frame_start: 1'b0, vsync: ~VSYNC_POL,
                                      hsync: ~HSYNC_POL, blank: 1'b1};

  logic [H_W-1:0]       h;
  logic [V_W-1:0]       v;
  logic [FB_ADDR_W-1:0] addr;
  logic                 active;
  logic                 frame_wrap;
  logic                 fb_rd_r;
  logic [FB_ADDR_W-1:0] fb_addr_r;
  vid_ctrl_t            ctrl_s0;
  vid_ctrl_t            ctrl_dly;

  assign active     = (h < H_ACT) && (v < V_ACT);
  assign frame_wrap = (h == H_LAST) && (v == V_LAST);

  // Address advances per issued pixel instead of computing v*H_ACTIVE+h.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      h    <= '0;
      v    <= '0;
      addr <= '0;
    end else begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (frame_wrap)  addr <= '0;
      else if (active) addr <= addr + 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fb_rd_r   <= 1'b0;
      fb_addr_r <= '0;
    end else begin
      fb_rd_r   <= active;
      fb_addr_r <= addr;
    end
  end

  assign fb.fb_rd   = fb_rd_r;
  assign fb.fb_addr = fb_addr_r;

  always_comb begin
    ctrl_s0             = CTRL_IDLE;
    ctrl_s0.frame_start = (h == '0) && (v == '0);
    ctrl_s0.vsync       = ((v >= VS_START) && (v < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    ctrl_s0.hsync       = ((h >= HS_START) && (h < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    ctrl_s0.blank       = ~active;
  end

  // One stage short of D: the output register below supplies the last stage.
  video_delay_line #(
    .DEPTH     (D - 1),
    .WIDTH     ($bits(vid_ctrl_t)),
    .RESET_VAL (CTRL_IDLE)
  ) u_ctrl_dly (
    .clk  (pclk),
    .rst  (rst),
    .din  (ctrl_s0),
    .dout (ctrl_dly)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      {out_vga_red, out_vga_green, out_vga_blue} <= '0;
      out_vga_blank   <= 1'b1;
      out_vga_hsync   <= ~HSYNC_POL;
      out_vga_vsync   <= ~VSYNC_POL;
      out_frame_start <= 1'b0;
    end else begin
      {out_vga_red, out_vga_green, out_vga_blue} <=
          ctrl_dly.blank ? 24'h0 : rgb565_to_888(fb.fb_data);
      out_vga_blank   <= ctrl_dly.blank;
      out_vga_hsync   <= ctrl_dly.hsync;
      out_vga_vsync   <= ctrl_dly.vsync;
      out_frame_start <= ctrl_dly.frame_start;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_scanout.sv
// ============================================================================
// tb_vga_scanout : reduced-geometry scanout bench against a frame-level model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vga_scanout;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int LAT = 2;
  localparam int D = LAT + 2;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic [7:0] red, green, blue;
  logic blank, hsync, vsync, frame_start;

  logic [15:0] mem [0:127];
  logic [15:0] mpipe [LAT];

  int tests  = 0;
  int failed = 0;
  int cur_k  = 0;

  vga_scanout_if #(.FB_ADDR_W(19)) fb_bus ();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FB_ADDR_W(19), .FB_LATENCY(LAT)
  ) dut (
    .pclk(pclk), .rst(rst), .fb(fb_bus),
    .out_vga_red(red), .out_vga_green(green), .out_vga_blue(blue),
    .out_vga_blank(blank), .out_vga_hsync(hsync), .out_vga_vsync(vsync),
    .out_frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  // Memory: sampled on the edge that sees fb_rd, LAT-register read pipeline.
  always @(posedge pclk) begin
    mpipe[0] <= mem[fb_bus.fb_addr[6:0]];
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign fb_bus.fb_data = mpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] px);
    int r5, g6, b5;
    r5 = int'(px) / 2048;
    g6 = (int'(px) / 32) % 64;
    b5 = int'(px) % 32;
    return 24'((r5 * 8 + r5 / 4) * 65536 + (g6 * 4 + g6 / 16) * 256 + (b5 * 8 + b5 / 4));
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"},    32'(fb_bus.fb_rd), 32'd0);
    chk({tag, "_addr"},  32'(fb_bus.fb_addr), 32'd0);
    chk({tag, "_rgb"},   32'({red, green, blue}), 32'd0);
    chk({tag, "_blank"}, 32'(blank), 32'd1);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
  endtask

  // k = pclk edges since reset release; fb bus reflects counter cycle k-1,
  // video outputs reflect counter cycle k-D.
  task automatic check_cycle(input int k);
    int c, h, v, exp_addr;
    bit act, exp_rd;
    logic [23:0] exp_rgb;
    cur_k = k;
    exp_rd = 1'b0;
    exp_addr = 0;
    if (k >= 1) begin
      c = k - 1;
      h = c % HT;
      v = (c / HT) % VT;
      exp_rd = (h < HA) && (v < VA);
      exp_addr = (v < VA) ? v * HA + ((h < HA) ? h : HA) : VA * HA;
    end
    chk("fb_rd",   32'(fb_bus.fb_rd), 32'(exp_rd));
    chk("fb_addr", 32'(fb_bus.fb_addr), 32'(exp_addr));
    c = k - D;
    if (c < 0) begin
      chk("pre_rgb",   32'({red, green, blue}), 32'd0);
      chk("pre_blank", 32'(blank), 32'd1);
      chk("pre_hsync", 32'(hsync), 32'd1);
      chk("pre_vsync", 32'(vsync), 32'd1);
      chk("pre_fs",    32'(frame_start), 32'd0);
    end else begin
      h = c % HT;
      v = (c / HT) % VT;
      act = (h < HA) && (v < VA);
      exp_rgb = act ? expand(mem[v * HA + h]) : 24'h0;
      chk("rgb",   32'({red, green, blue}), 32'(exp_rgb));
      chk("blank", 32'(blank), 32'(!act));
      chk("hsync", 32'(hsync), 32'(!((h >= HA + HFP) && (h < HA + HFP + HS))));
      chk("vsync", 32'(vsync), 32'(!((v >= VA + VFP) && (v < VA + VFP + VS))));
      chk("fs",    32'(frame_start), 32'((h == 0) && (v == 0)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, fs_cnt, hs_low, bl_low, vs_low;

    // Phase 1: random frame contents, two full frames.
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge pclk);
    cur_k = -1;
    chk_reset("hold_rst");
    rst = 1'b0;
    check_cycle(0);
    rd_cnt = 0; fs_cnt = 0; hs_low = 0; bl_low = 0; vs_low = 0;
    for (int k = 1; k < 2 * FT + D; k++) begin
      @(negedge pclk);
      check_cycle(k);
      if (k <= FT && fb_bus.fb_rd) rd_cnt++;
      if (frame_start) fs_cnt++;
      if (k >= D && k < D + HT && !hsync) hs_low++;
      if (k >= D && k < D + HT && !blank) bl_low++;
      if (k >= D && k < D + FT && !vsync) vs_low++;
    end
    cur_k = -1;
    chk("rd_per_frame",    32'(rd_cnt), 32'(HA * VA));
    chk("fs_pulses",       32'(fs_cnt), 32'd2);
    chk("hsync_low_len",   32'(hs_low), 32'(HS));
    chk("blank_low_len",   32'(bl_low), 32'(HA));
    chk("vsync_low_len",   32'(vs_low), 32'(VS * HT));

    // Mid-line reset: outputs must return to idle without waiting for an edge.
    repeat ($urandom_range(30, 5)) @(negedge pclk);
    @(posedge pclk);
    #1 rst = 1'b1;
    #1 chk_reset("mid_rst");

    // Phase 2: directed colours, everything else full white.
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    mem[0] = 16'hF800;
    mem[1] = 16'h07E0;
    mem[2] = 16'h001F;
    mem[3] = 16'h8410;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    check_cycle(0);
    for (int k = 1; k < FT + D + 2; k++) begin
      @(negedge pclk);
      check_cycle(k);
      if (k == D)     chk("red_px",   32'({red, green, blue}), 32'h00FF0000);
      if (k == D + 1) chk("green_px", 32'({red, green, blue}), 32'h0000FF00);
      if (k == D + 2) chk("blue_px",  32'({red, green, blue}), 32'h000000FF);
      if (k == D + 3) chk("grey_px",  32'({red, green, blue}), 32'h00848284);
      if (k == D + 4) chk("white_px", 32'({red, green, blue}), 32'h00FFFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
